cnt_share_array_gen: RTL and testbench

//  Shared unary-bitstream index counter with programmable period, one-shot or free-running mode,
//  and a start/clear control FSM. The count is fanned out through TDIM register-pipelined buffer

---
 rtl/cnt_share_pkg.sv | 20 ++
 rtl/cnt_share_pipe.sv | 45 ++++
 rtl/cnt_share_array_gen.sv | 101 ++++++++++
 tb/tb_cnt_share_array_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_share_pkg.sv
// rtl/cnt_share_pkg.sv - shared types, limits and wrap-point helper for the shared index counter
package cnt_share_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } cnt_state_t;

    // Deepest fan-out delay line; deeper requests are clamped to this.
    localparam int PDEP_MAX = 4;

    // Last count value before wrap. A period of 0 means the full 2^cwid range,
    // so the wrap point is all-ones and the counter overflows naturally.
    function automatic logic [31:0] last_of(input logic [31:0] per, input int cwid);
        logic [31:0] all_ones;
        all_ones = (cwid >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cwid) - 32'd1);
        return (per == 32'd0) ? all_ones : (per - 32'd1);
    endfunction

endpackage

// File: rtl/cnt_share_pipe.sv
// rtl/cnt_share_pipe.sv - one buffer group's (count, valid) register delay line
module cnt_share_pipe
    import cnt_share_pkg::*;
#(
    parameter int CWID = 10,
    parameter int PDEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CWID-1:0] cnt_in,
    input  logic            valid_in,
    output logic [CWID-1:0] cnt_out,
    output logic            valid_out
);

    localparam int DEPTH = (PDEP > PDEP_MAX) ? PDEP_MAX : PDEP;

    if (DEPTH == 0) begin : g_tap
        assign cnt_out   = cnt_in;
        assign valid_out = valid_in;
    end else begin : g_reg
        // Kept as a distinct flop set per group so each group can be placed near its consumers.
        (* keep = "true" *) logic [DEPTH-1:0][CWID-1:0] cnt_q;
        (* keep = "true" *) logic [DEPTH-1:0]           valid_q;

        // Shift (count, valid) one stage per clock; stage 0 samples the live counter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                valid_q <= '0;
            end else begin
                cnt_q[0]   <= cnt_in;
                valid_q[0] <= valid_in;
                for (int i = 1; i < DEPTH; i++) begin
                    cnt_q[i]   <= cnt_q[i-1];
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end

        assign cnt_out   = cnt_q[DEPTH-1];
        assign valid_out = valid_q[DEPTH-1];
    end

endmodule

// File: rtl/cnt_share_array_gen.sv
// rtl/cnt_share_array_gen.sv - shared programmable-period index counter with start/clear FSM and buffered fan-out
module cnt_share_array_gen
    import cnt_share_pkg::*;
#(
    parameter int  CWID = 10,
    parameter int  BDIM = 1,
    parameter int  SDIM = 32,
    parameter int  PDEP = 1,
    localparam int TDIM = (BDIM < 1) ? 1 : BDIM
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            clear,
    input  logic                            enable,
    input  logic [CWID-1:0]                 period,
    input  logic                            oneshot,
    output logic                            busy,
    output logic                            wrap,
    output logic [TDIM*SDIM-1:0][CWID-1:0]  cntSeq,
    output logic [TDIM-1:0]                 validSeq
);

    cnt_state_t      state;
    logic [CWID-1:0] cnt;
    logic [CWID-1:0] per_reg;
    logic            mode_reg;
    logic [CWID-1:0] last;
    logic            v0;

    assign last = CWID'(last_of(32'(per_reg), CWID));
    assign busy = (state == S_RUN);
    assign v0   = busy & enable;

    // Control FSM, counter and run configuration; clear overrides everything but reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            per_reg  <= '0;
            mode_reg <= 1'b0;
            wrap     <= 1'b0;
        end else if (clear) begin
            state <= S_IDLE;
            cnt   <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        per_reg  <= period;
                        mode_reg <= oneshot;
                        cnt      <= '0;
                    end
                end
                S_RUN: begin
                    if (enable) begin
                        if (cnt == last) begin
                            cnt  <= '0;
                            wrap <= 1'b1;
                            if (mode_reg) begin
                                state <= S_IDLE;
                            end
                        end else begin
                            cnt <= cnt + CWID'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < TDIM; g++) begin : g_grp
        logic [CWID-1:0] grp_cnt;
        logic            grp_valid;

        (* keep = "true" *) cnt_share_pipe #(
            .CWID (CWID),
            .PDEP (PDEP)
        ) u_pipe (
            .clk       (clk),
            .rst_n     (rst_n),
            .cnt_in    (cnt),
            .valid_in  (v0),
            .cnt_out   (grp_cnt),
            .valid_out (grp_valid)
        );

        assign validSeq[g] = grp_valid;

        for (genvar s = 0; s < SDIM; s++) begin : g_lane
            assign cntSeq[g*SDIM+s] = grp_cnt;
        end
    end

endmodule

// File: tb/tb_cnt_share_array_gen.sv
// tb/tb_cnt_share_array_gen.sv - scoreboard bench for the shared index counter
module tb_cnt_share_array_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic start, clear, enable, oneshot;
    logic [3:0] period;

    logic             busy_a, wrap_a;
    logic [7:0][3:0]  cnt_a;
    logic [1:0]       valid_a;
    logic             busy_b, wrap_b;
    logic [1:0][3:0]  cnt_b;
    logic [0:0]       valid_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int         due;
        logic [3:0] c;
    } exp_t;

    typedef struct {
        logic       st, cl, en;
        logic [3:0] per;
        logic       os, v;
        logic [3:0] c;
        logic       b, w;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t vq[$];

    cnt_share_array_gen #(.CWID(4), .BDIM(2), .SDIM(4), .PDEP(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .enable(enable),
        .period(period), .oneshot(oneshot), .busy(busy_a), .wrap(wrap_a),
        .cntSeq(cnt_a), .validSeq(valid_a)
    );

    cnt_share_array_gen #(.CWID(4), .BDIM(0), .SDIM(2), .PDEP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .enable(enable),
        .period(period), .oneshot(oneshot), .busy(busy_b), .wrap(wrap_b),
        .cntSeq(cnt_b), .validSeq(valid_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor for the PDEP=3, two-group instance.
    always @(negedge clk) begin
        exp_t e;
        int bad;
        if (valid_a != 2'b00) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_valid", int'(valid_a), 0);
            end else begin
                e = q_a.pop_front();
                chk("a_lag", cyc, e.due);
                chk("a_valid_groups", int'(valid_a), 3);
                bad = -1;
                for (int k = 0; k < 8; k++) if (cnt_a[k] != e.c && bad < 0) bad = k;
                chk("a_lanes", (bad < 0) ? int'(e.c) : int'(cnt_a[bad]), int'(e.c));
            end
        end else if (q_a.size() > 0 && q_a[0].due <= cyc) begin
            e = q_a.pop_front();
            chk("a_missing_valid", int'(valid_a), 3);
        end
    end

    // Monitor for the BDIM=0, PDEP=1 instance (legacy one-cycle lag).
    always @(negedge clk) begin
        exp_t e;
        if (valid_b != 1'b0) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_valid", int'(valid_b), 0);
            end else begin
                e = q_b.pop_front();
                chk("b_lag", cyc, e.due);
                chk("b_lane0", int'(cnt_b[0]), int'(e.c));
                chk("b_lane1", int'(cnt_b[1]), int'(e.c));
            end
        end else if (q_b.size() > 0 && q_b[0].due <= cyc) begin
            e = q_b.pop_front();
            chk("b_missing_valid", int'(valid_b), 1);
        end
    end

    task automatic add(input logic st, cl, en, input logic [3:0] per, input logic os,
                       input logic v, input logic [3:0] c, input logic b, w);
        vec_t x;
        x.st = st; x.cl = cl; x.en = en; x.per = per; x.os = os;
        x.v = v; x.c = c; x.b = b; x.w = w;
        vq.push_back(x);
    endtask

    // Called at posedge+1: apply one cycle of stimulus, queue its expected output, check control outputs.
    task automatic drive(input vec_t x);
        start = x.st; clear = x.cl; enable = x.en; period = x.per; oneshot = x.os;
        if (x.v) begin
            q_a.push_back('{cyc + 3, x.c});
            q_b.push_back('{cyc + 1, x.c});
        end
        @(posedge clk); #1;
        chk("busy_a", int'(busy_a), int'(x.b));
        chk("wrap_a", int'(wrap_a), int'(x.w));
        chk("busy_b", int'(busy_b), int'(x.b));
        chk("wrap_b", int'(wrap_b), int'(x.w));
    endtask

    task automatic check_reset_outputs(input string tag);
        int nz;
        nz = 0;
        for (int k = 0; k < 8; k++) if (cnt_a[k] != 4'd0) nz++;
        for (int k = 0; k < 2; k++) if (cnt_b[k] != 4'd0) nz++;
        chk({tag, "_lanes_nonzero"}, nz, 0);
        chk({tag, "_valid_a"}, int'(valid_a), 0);
        chk({tag, "_valid_b"}, int'(valid_b), 0);
        chk({tag, "_busy"}, int'(busy_a | busy_b), 0);
        chk({tag, "_wrap"}, int'(wrap_a | wrap_b), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; enable = 1'b1; period = 4'd0; oneshot = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // period=5 free-running; a start with period=2 mid-run is ignored
        add(1,0,0,4'd5,0, 0,4'd0, 1,0);
        add(0,0,1,4'd5,0, 1,4'd0, 1,0);
        add(0,0,1,4'd5,0, 1,4'd1, 1,0);
        add(0,0,1,4'd5,0, 1,4'd2, 1,0);
        add(0,0,1,4'd5,0, 1,4'd3, 1,0);
        add(0,0,1,4'd5,0, 1,4'd4, 1,1);
        add(0,0,1,4'd5,0, 1,4'd0, 1,0);
        add(1,0,1,4'd2,0, 1,4'd1, 1,0);
        add(0,0,1,4'd2,0, 1,4'd2, 1,0);
        add(0,0,1,4'd5,0, 1,4'd3, 1,0);
        add(0,0,1,4'd5,0, 1,4'd4, 1,1);
        add(0,0,1,4'd5,0, 1,4'd0, 1,0);
        add(0,0,1,4'd5,0, 1,4'd1, 1,0);
        add(0,1,1,4'd5,0, 1,4'd2, 0,0);
        add(0,0,1,4'd5,0, 0,4'd0, 0,0);

        // period=3 one-shot: single wrap, then idle with enable still high
        add(1,0,1,4'd3,1, 0,4'd0, 1,0);
        add(0,0,1,4'd3,1, 1,4'd0, 1,0);
        add(0,0,1,4'd3,1, 1,4'd1, 1,0);
        add(0,0,1,4'd3,1, 1,4'd2, 0,1);
        add(0,0,1,4'd3,1, 0,4'd0, 0,0);
        add(0,0,1,4'd3,1, 0,4'd0, 0,0);

        // period=10, input period changed to 3 mid-run, clear & start together at cnt=7
        add(1,0,0,4'd10,0, 0,4'd0, 1,0);
        for (int k = 0; k < 7; k++) add(0,0,1,4'd3,0, 1,4'(k), 1,0);
        add(1,1,1,4'd3,0, 1,4'd7, 0,0);
        add(0,0,1,4'd3,0, 0,4'd0, 0,0);

        // period=0 (full 16) with enable toggling every cycle
        add(1,0,0,4'd0,0, 0,4'd0, 1,0);
        for (int k = 0; k < 16; k++) begin
            add(0,0,1,4'd0,0, 1,4'(k), 1,(k == 15));
            add(0,0,0,4'd0,0, 0,4'((k + 1) % 16), 1,0);
        end
        add(0,1,0,4'd0,0, 0,4'd0, 0,0);
        for (int k = 0; k < 4; k++) add(0,0,0,4'd0,0, 0,4'd0, 0,0);

        // period=2 run up to a wrap, then asynchronous reset mid-run
        add(1,0,0,4'd2,0, 0,4'd0, 1,0);
        add(0,0,1,4'd2,0, 1,4'd0, 1,0);
        add(0,0,1,4'd2,0, 1,4'd1, 1,1);

        while (vq.size() > 0) begin
            vec_t x;
            x = vq.pop_front();
            if (x.st && x.per == 4'd2 && !x.en) begin
                chk("drained_a", q_a.size(), 0);
                chk("drained_b", q_b.size(), 0);
            end
            drive(x);
        end

        #2;
        rst_n = 1'b0;
        #1;
        q_a.delete();
        q_b.delete();
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
